// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline register file with scoreboard.
// Holds the default geometry, the hardwired-zero register index and the
// register address type for the default depth.
package pipeline_pkg;

    localparam int REG_WIDTH = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = $clog2(REG_DEPTH);

    typedef logic [REG_AW-1:0] reg_addr_t;

    // Register 0 always reads zero and can never be reserved.
    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : pipeline_pkg

// File: rtl/regfile_scoreboard_bits.sv
// Pending-write scoreboard for the register file.
// Keeps one pending bit per register plus a registered population count.
// A reservation issued in the same cycle as a writeback to the same register
// wins, since it belongs to a younger instruction.
//
// Ports:
//   CLK            rising-edge clock
//   RESET          synchronous active-high reset, clears every pending bit
//   writeEnable    writeback strobe (clears the destination's pending bit)
//   writeAddress   writeback destination
//   reserveEnable  decode reservation strobe (sets the pending bit)
//   reserveAddress register being reserved
//   pending        current pending vector (bit 0 is always 0)
//   pendingCount   number of set pending bits
module regfile_scoreboard_bits
    import pipeline_pkg::*;
#(
    parameter  int DEPTH = REG_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          writeEnable,
    input  logic [AW-1:0] writeAddress,
    input  logic          reserveEnable,
    input  logic [AW-1:0] reserveAddress,
    output logic [DEPTH-1:0] pending,
    output logic [AW:0]   pendingCount
);

    logic [DEPTH-1:0] pending_r;
    logic [DEPTH-1:0] pending_next_s;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic             write_valid_s;
    logic             reserve_valid_s;
    logic             inc_s;
    logic             dec_s;

    assign write_valid_s   = writeEnable   && (writeAddress   != AW'(ZERO_REG));
    assign reserve_valid_s = reserveEnable && (reserveAddress != AW'(ZERO_REG));

    // Next pending vector: reservation has priority over a same-register clear.
    always_comb begin
        pending_next_s = pending_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (reserve_valid_s && (reserveAddress == AW'(i))) begin
                pending_next_s[i] = 1'b1;
            end else if (write_valid_s && (writeAddress == AW'(i))) begin
                pending_next_s[i] = 1'b0;
            end else begin
                pending_next_s[i] = pending_r[i];
            end
        end
        pending_next_s[0] = 1'b0;
    end

    // Incremental count: +1 when a clear bit gets set, -1 when a set bit gets
    // cleared; a write cancelled by a same-register reservation clears nothing.
    always_comb begin
        inc_s = reserve_valid_s && !pending_r[reserveAddress];
        dec_s = write_valid_s && pending_r[writeAddress]
                && !(reserve_valid_s && (reserveAddress == writeAddress));
        count_next_s = count_r + (AW+1)'(inc_s) - (AW+1)'(dec_s);
    end

    // Pending vector and counter registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending_r <= '0;
            count_r   <= '0;
        end else begin
            pending_r <= pending_next_s;
            count_r   <= count_next_s;
        end
    end

    assign pending      = pending_r;
    assign pendingCount = count_r;

endmodule : regfile_scoreboard_bits

// File: rtl/register_file_scoreboard.sv
// Pipeline register file with write-to-read bypass and pending-write scoreboard.
// Register 0 is hardwired to zero. Reads are combinational; a same-cycle
// writeback to the addressed register is forwarded (write-first) and masks
// that port's busy flag, because the forwarded value is already valid.
//
// Ports:
//   CLK            rising-edge clock
//   RESET          synchronous active-high reset (clears data and scoreboard)
//   readAddress    packed read addresses, port i at [i*AW +: AW]
//   readData       packed read data, port i at [i*WIDTH +: WIDTH]
//   readBusy       per-port: addressed register has an outstanding reservation
//   writeEnable    writeback strobe
//   writeAddress   writeback destination
//   writeData      writeback value
//   reserveEnable  decode reservation strobe
//   reserveAddress register being reserved
//   pendingCount   number of registers currently pending
module register_file_scoreboard
    import pipeline_pkg::*;
#(
    parameter  int WIDTH = REG_WIDTH,
    parameter  int DEPTH = REG_DEPTH,
    parameter  int NREAD = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NREAD*AW-1:0]   readAddress,
    output logic [NREAD*WIDTH-1:0] readData,
    output logic [NREAD-1:0]      readBusy,
    input  logic                  writeEnable,
    input  logic [AW-1:0]         writeAddress,
    input  logic [WIDTH-1:0]      writeData,
    input  logic                  reserveEnable,
    input  logic [AW-1:0]         reserveAddress,
    output logic [AW:0]           pendingCount
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0] pending_s;
    logic [AW-1:0]    rd_addr_s [NREAD];
    logic             write_valid_s;

    assign write_valid_s = writeEnable && (writeAddress != AW'(ZERO_REG));

    regfile_scoreboard_bits #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .CLK            (CLK),
        .RESET          (RESET),
        .writeEnable    (writeEnable),
        .writeAddress   (writeAddress),
        .reserveEnable  (reserveEnable),
        .reserveAddress (reserveAddress),
        .pending        (pending_s),
        .pendingCount   (pendingCount)
    );

    // Data array; entry 0 is never written so it stays zero after reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (write_valid_s) begin
            mem_r[writeAddress] <= writeData;
        end else begin
            mem_r[writeAddress] <= mem_r[writeAddress];
        end
    end

    // Read ports: zero register, then bypass, then stored value.
    always_comb begin
        readData  = '0;
        readBusy  = '0;
        rd_addr_s = '{default: '0};
        for (int p = 0; p < NREAD; p++) begin
            rd_addr_s[p] = readAddress[p*AW +: AW];
            if (rd_addr_s[p] == AW'(ZERO_REG)) begin
                readData[p*WIDTH +: WIDTH] = '0;
                readBusy[p]                = 1'b0;
            end else if (write_valid_s && (writeAddress == rd_addr_s[p])) begin
                readData[p*WIDTH +: WIDTH] = writeData;
                readBusy[p]                = 1'b0;
            end else begin
                readData[p*WIDTH +: WIDTH] = mem_r[rd_addr_s[p]];
                readBusy[p]                = pending_s[rd_addr_s[p]];
            end
        end
    end

endmodule : register_file_scoreboard

// File: tb/tb_register_file_scoreboard.sv
module tb_register_file_scoreboard;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 2;
    localparam int AW = 5;

    logic              CLK;
    logic              RESET;
    logic [NR*AW-1:0]  readAddress;
    logic [NR*W-1:0]   readData;
    logic [NR-1:0]     readBusy;
    logic              writeEnable;
    logic [AW-1:0]     writeAddress;
    logic [W-1:0]      writeData;
    logic              reserveEnable;
    logic [AW-1:0]     reserveAddress;
    logic [AW:0]       pendingCount;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural contents and the set of reserved registers.
    logic [W-1:0] model_mem [D];
    bit           model_pend [D];

    register_file_scoreboard #(.WIDTH(W), .DEPTH(D), .NREAD(NR)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .readAddress    (readAddress),
        .readData       (readData),
        .readBusy       (readBusy),
        .writeEnable    (writeEnable),
        .writeAddress   (writeAddress),
        .writeData      (writeData),
        .reserveEnable  (reserveEnable),
        .reserveAddress (reserveAddress),
        .pendingCount   (pendingCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(model_pend[i]);
        return c;
    endfunction

    // What a reader of register a must see right now, given the current inputs.
    function automatic logic [W-1:0] exp_data(int a);
        if (a == 0) return 32'd0;
        if (writeEnable && int'(writeAddress) == a) return writeData;
        return model_mem[a];
    endfunction

    function automatic bit exp_busy(int a);
        if (a == 0) return 1'b0;
        if (writeEnable && int'(writeAddress) == a) return 1'b0;
        return model_pend[a];
    endfunction

    // Apply the architectural effect of the current inputs, then advance a clock.
    task automatic tick();
        if (RESET) begin
            for (int i = 0; i < D; i++) begin
                model_mem[i]  = 32'd0;
                model_pend[i] = 1'b0;
            end
        end else begin
            if (writeEnable && writeAddress != 5'd0) begin
                model_mem[writeAddress]  = writeData;
                model_pend[writeAddress] = 1'b0;
            end
            if (reserveEnable && reserveAddress != 5'd0)
                model_pend[reserveAddress] = 1'b1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(bit we, int wa, logic [W-1:0] wd, bit re, int ra, int a0, int a1);
        writeEnable    = we;
        writeAddress   = AW'(wa);
        writeData      = wd;
        reserveEnable  = re;
        reserveAddress = AW'(ra);
        readAddress    = {AW'(a1), AW'(a0)};
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        drive(1'b1, 5, 32'hDEADBEEF, 1'b1, 5, 5, 0);
        tick();
        drive(1'b0, 0, 32'd0, 1'b0, 0, 5, 0);
        n_checks++;
        if (readData[31:0] !== 32'hDEADBEEF || pendingCount !== 6'd1) begin
            n_errors++;
            $display("FAIL reset_pre: data=%h cnt=%0d required data=deadbeef cnt=1", readData[31:0], pendingCount);
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        drive(1'b0, 0, 32'd0, 1'b0, 0, 5, 5);
        n_checks++;
        if (readData[31:0] !== 32'd0 || readBusy !== 2'b00 || pendingCount !== 6'd0) begin
            n_errors++;
            $display("FAIL reset_clear: data=%h busy=%b cnt=%0d required 0/00/0", readData[31:0], readBusy, pendingCount);
        end
        RESET = 1'b1;
        drive(1'b1, 7, 32'h77777777, 1'b1, 7, 7, 7);
        tick();
        RESET = 1'b0;
        drive(1'b0, 0, 32'd0, 1'b0, 0, 7, 7);
        n_checks++;
        if (readData[31:0] !== 32'd0 || readBusy !== 2'b00 || pendingCount !== 6'd0) begin
            n_errors++;
            $display("FAIL reset_dominates: data=%h busy=%b cnt=%0d required 0/00/0", readData[31:0], readBusy, pendingCount);
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b0, 0, 32'd0, 1'b1, 4, 0, 0);
        tick();
        drive(1'b1, 0, 32'h00001234, 1'b1, 0, 0, 0);
        n_checks++;
        if (readData !== 64'd0 || readBusy !== 2'b00) begin
            n_errors++;
            $display("FAIL zero_bypass: data=%h busy=%b required 0/00", readData, readBusy);
        end
        tick();
        drive(1'b0, 0, 32'd0, 1'b0, 0, 0, 0);
        n_checks++;
        if (readData !== 64'd0 || readBusy !== 2'b00 || pendingCount !== 6'd1) begin
            n_errors++;
            $display("FAIL zero_after: data=%h busy=%b cnt=%0d required 0/00/1", readData, readBusy, pendingCount);
        end
        drive(1'b1, 4, 32'h44444444, 1'b0, 0, 4, 0);
        tick();
    endtask

    task automatic test_bypass();
        drive(1'b1, 3, 32'h11111111, 1'b0, 0, 0, 0);
        tick();
        drive(1'b1, 3, 32'hA5A5A5A5, 1'b0, 0, 3, 3);
        n_checks++;
        if (readData !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
            n_errors++;
            $display("FAIL bypass_same_cycle: got=%h required a5a5a5a5a5a5a5a5", readData);
        end
        tick();
        drive(1'b0, 3, 32'h0BADF00D, 1'b0, 0, 3, 3);
        n_checks++;
        if (readData !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
            n_errors++;
            $display("FAIL bypass_array: got=%h required a5a5a5a5a5a5a5a5", readData);
        end
    endtask

    task automatic test_scoreboard();
        drive(1'b0, 0, 32'd0, 1'b1, 8, 8, 0);
        tick();
        drive(1'b0, 0, 32'd0, 1'b0, 0, 8, 0);
        n_checks++;
        if (readBusy[0] !== 1'b1 || pendingCount !== 6'd1) begin
            n_errors++;
            $display("FAIL sb_reserve: busy=%b cnt=%0d required 1/1", readBusy[0], pendingCount);
        end
        drive(1'b1, 8, 32'h88888888, 1'b0, 0, 8, 8);
        n_checks++;
        if (readBusy !== 2'b00 || readData[63:32] !== 32'h88888888) begin
            n_errors++;
            $display("FAIL sb_write_mask: busy=%b data=%h required 00/88888888", readBusy, readData[63:32]);
        end
        tick();
        drive(1'b0, 0, 32'd0, 1'b0, 0, 8, 0);
        n_checks++;
        if (readBusy !== 2'b00 || pendingCount !== 6'd0) begin
            n_errors++;
            $display("FAIL sb_clear: busy=%b cnt=%0d required 00/0", readBusy, pendingCount);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 0, 32'd0, 1'b1, 9, 0, 0);
        tick();
        drive(1'b1, 9, 32'd7, 1'b1, 9, 0, 0);
        tick();
        drive(1'b0, 0, 32'd0, 1'b0, 0, 9, 0);
        n_checks++;
        if (readData[31:0] !== 32'd7 || readBusy[0] !== 1'b1 || pendingCount !== 6'd1) begin
            n_errors++;
            $display("FAIL simul_wr_res: data=%h busy=%b cnt=%0d required 7/1/1", readData[31:0], readBusy[0], pendingCount);
        end
        drive(1'b0, 0, 32'd0, 1'b1, 9, 9, 0);
        tick();
        drive(1'b0, 0, 32'd0, 1'b0, 0, 9, 0);
        n_checks++;
        if (readBusy[0] !== 1'b1 || pendingCount !== 6'd1) begin
            n_errors++;
            $display("FAIL simul_waw: busy=%b cnt=%0d required 1/1", readBusy[0], pendingCount);
        end
        drive(1'b1, 9, 32'd9, 1'b0, 0, 0, 0);
        tick();
        drive(1'b1, 10, 32'd10, 1'b0, 0, 10, 0);
        tick();
        drive(1'b0, 0, 32'd0, 1'b0, 0, 10, 0);
        n_checks++;
        if (pendingCount !== 6'd0 || readData[31:0] !== 32'd10) begin
            n_errors++;
            $display("FAIL simul_nonpending_write: cnt=%0d data=%h required 0/0000000a", pendingCount, readData[31:0]);
        end
    endtask

    task automatic test_random();
        int a0, a1;
        logic [W-1:0] e0, e1;
        bit b0, b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            RESET = ($urandom_range(0, 99) == 0);
            a0 = $urandom_range(0, 15);
            a1 = $urandom_range(0, 15);
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 15), a0, a1);
            e0 = exp_data(a0);
            e1 = exp_data(a1);
            b0 = exp_busy(a0);
            b1 = exp_busy(a1);
            n_checks++;
            if (readData !== {e1, e0} || readBusy !== {b1, b0}) begin
                n_errors++;
                $display("FAIL rand_read cyc=%0d: data=%h busy=%b required data=%h busy=%b",
                         cyc, readData, readBusy, {e1, e0}, {b1, b0});
            end
            tick();
            n_checks++;
            if (int'(pendingCount) !== model_count()) begin
                n_errors++;
                $display("FAIL rand_count cyc=%0d: cnt=%0d required %0d", cyc, pendingCount, model_count());
            end
        end
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b0, 0, 32'd0, 1'b0, 0, 0, 0);
        tick();
        RESET = 1'b0;
        drive(1'b0, 0, 32'd0, 1'b0, 0, 1, 2);
        n_checks++;
        if (readData !== 64'd0 || readBusy !== 2'b00 || pendingCount !== 6'd0) begin
            n_errors++;
            $display("FAIL initial_reset: data=%h busy=%b cnt=%0d required 0/00/0", readData, readBusy, pendingCount);
        end
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_register_file_scoreboard
